// File: rtl/seg_mux_pkg.sv
// seg_mux_pkg: shared types and constants for the seg_mux display driver.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, default timing constants, anode encodings and
// the slot-counter width helper.
package seg_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW0,
    GAP0,
    SHOW1,
    GAP1
  } state_t;

  localparam int DWELL_DEF = 24000;
  localparam int BLANK_DEF = 512;

  // Common-anode drive through PNP switches: a 0 turns a digit on.
  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;

  // Counter width sized for the longer of the two slot types.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seg_mux_if.sv
// seg_mux_if: bundles the display enable, digit inputs and display outputs.
// Latency: n/a (wires only).
// Backpressure: none; the display free-runs and never stalls its source.
// Ports: en, d0, d1 flow into the driver; nib, an, frame flow out.
// master = the controller/bench side, slave = the seg_mux side.
interface seg_mux_if;
  logic       en;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] nib;
  logic [1:0] an;
  logic       frame;

  modport master (output en, d0, d1, input nib, an, frame);
  modport slave  (input en, d0, d1, output nib, an, frame);
endinterface

// File: rtl/seg_mux_slot_counter.sv
// slot_counter: shared slot timer; counts up to a selectable terminal value.
// Latency: tc is combinational from the cnt register; cnt updates each clock.
// Backpressure: none; clr forces the count back to zero.
// Ports: clk, reset (sync, active-high), clr (sync clear), last (terminal
// value), cnt (current count), tc (cnt == last).
module slot_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == last);

  // Returns to zero at the terminal count so it never runs past a slot end.
  always_ff @(posedge clk) begin
    if (reset || clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_mux.sv
// seg_mux: time-multiplexes two hex digits onto one nibble bus with active-low anodes.
// Latency: en high in IDLE at edge t shows digit 0 (with frame) in cycle t+1.
// Backpressure: none; en low or reset blanks the display on the next cycle.
// Ports: clk, reset (sync, active-high), bus (seg_mux_if.slave: en, d0, d1 in;
// nib, an, frame out). Parameters DWELL (cycles lit, >=2), BLANK (gap cycles, >=1).
// Define SEG_MUX_BLANK_EN to insert BLANK-cycle dark gaps after each digit.
module seg_mux
  import seg_mux_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input logic        clk,
  input logic        reset,
  seg_mux_if.slave   bus
);

  localparam int CW = cnt_width(DWELL, BLANK);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
`ifdef SEG_MUX_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
`endif

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    d0q;
  logic [3:0]    d0q_nxt;
  logic [3:0]    d1q;
  logic [3:0]    d1q_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic          tc;
  logic          clr;
  logic [1:0]    an;
  logic [3:0]    nib;

  // One timer serves every state; only its terminal value changes per state.
  always_comb begin
    last = DWELL_LAST;
`ifdef SEG_MUX_BLANK_EN
    if (state == GAP0 || state == GAP1) begin
      last = BLANK_LAST;
    end
`endif
  end

  // Held at zero while idle so every start enters SHOW0 with cnt==0.
  assign clr = !bus.en || (state == IDLE);

  slot_counter #(.W(CW)) u_slot_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .last  (last),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d0q   <= '0;
      d1q   <= '0;
    end else begin
      state <= state_nxt;
      d0q   <= d0q_nxt;
      d1q   <= d1q_nxt;
    end
  end

  // Digits are captured only on entry to their SHOW slot.
  always_comb begin
    state_nxt = state;
    d0q_nxt   = d0q;
    d1q_nxt   = d1q;
    if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW0;
          d0q_nxt   = bus.d0;
        end
        SHOW0: begin
          if (tc) begin
`ifdef SEG_MUX_BLANK_EN
            state_nxt = GAP0;
`else
            state_nxt = SHOW1;
            d1q_nxt   = bus.d1;
`endif
          end
        end
`ifdef SEG_MUX_BLANK_EN
        GAP0: begin
          if (tc) begin
            state_nxt = SHOW1;
            d1q_nxt   = bus.d1;
          end
        end
`endif
        SHOW1: begin
          if (tc) begin
`ifdef SEG_MUX_BLANK_EN
            state_nxt = GAP1;
`else
            state_nxt = SHOW0;
            d0q_nxt   = bus.d0;
`endif
          end
        end
`ifdef SEG_MUX_BLANK_EN
        GAP1: begin
          if (tc) begin
            state_nxt = SHOW0;
            d0q_nxt   = bus.d0;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs depend on registers only; gaps keep the digit on nib but anodes off.
  always_comb begin
    an  = AN_OFF;
    nib = 4'h0;
    case (state)
      SHOW0: begin
        an  = AN_D0;
        nib = d0q;
      end
      GAP0:  nib = d0q;
      SHOW1: begin
        an  = AN_D1;
        nib = d1q;
      end
      GAP1:  nib = d1q;
      default: ;
    endcase
  end

  assign bus.an    = an;
  assign bus.nib   = nib;
  assign bus.frame = (state == SHOW0) && (cnt == '0);

endmodule

// File: tb/tb_seg_mux.sv
// tb_seg_mux: self-checking bench for seg_mux with DWELL=4, BLANK=2.
// A time-since-start display model is compared against the DUT every cycle,
// and directed scenarios pin key cycles with literal expected values.
module tb_seg_mux;
  import seg_mux_pkg::*;

  localparam int DW = 4;
  localparam int BL = 2;
`ifdef SEG_MUX_BLANK_EN
  localparam int GAPS = 1;
`else
  localparam int GAPS = 0;
`endif
  localparam int PER = GAPS ? 2 * (DW + BL) : 2 * DW;
  localparam int S1  = GAPS ? DW + BL : DW;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seg_mux_if bus();

  seg_mux #(.DWELL(DW), .BLANK(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the display is either dark or at phase t of a repeating frame.
  bit         run = 0;
  int         t = 0;
  logic [3:0] m0 = 4'h0;
  logic [3:0] m1 = 4'h0;

  always @(posedge clk) begin
    if (reset || !bus.en) begin
      run = 0;
      t   = 0;
      if (reset) begin
        m0 = 4'h0;
        m1 = 4'h0;
      end
    end else if (!run) begin
      run = 1;
      t   = 0;
      m0  = bus.d0;
    end else begin
      t = (t + 1) % PER;
      if (t == 0)  m0 = bus.d0;
      if (t == S1) m1 = bus.d1;
    end
  end

  always @(posedge clk) begin
    int e_an;
    int e_nib;
    int e_fr;
    #2;
    e_an  = 3;
    e_nib = 0;
    e_fr  = 0;
    if (run) begin
      if (t < DW) begin
        e_an  = 2;
        e_nib = m0;
        e_fr  = (t == 0);
      end else if (t < S1) begin
        e_an  = 3;
        e_nib = m0;
      end else if (t < S1 + DW) begin
        e_an  = 1;
        e_nib = m1;
      end else begin
        e_an  = 3;
        e_nib = m1;
      end
    end
    chk("model_an", bus.an, e_an);
    chk("model_nib", bus.nib, e_nib);
    chk("model_frame", bus.frame, e_fr);
    chk("an_both_low", (bus.an == 2'b00), 0);
  end

  logic [1:0] an_tab  [PER];
  logic [3:0] nib_tab [PER];

  initial begin
`ifdef SEG_MUX_BLANK_EN
    an_tab  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    nib_tab = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3,
                4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
`else
    an_tab  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    nib_tab = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hA, 4'hA, 4'hA, 4'hA};
`endif
    reset  = 1'b1;
    bus.en = 1'b1;
    bus.d0 = 4'h3;
    bus.d1 = 4'hA;

    // Reset held three cycles with en high.
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", bus.an, 2'b11);
      chk("rst_nib", bus.nib, 0);
      chk("rst_frame", bus.frame, 0);
    end
    reset = 1'b0;
    #1;
    chk("idle_after_release_an", bus.an, 2'b11);
    chk("idle_after_release_frame", bus.frame, 0);

    // One full frame plus the start of the next, against literal tables.
    for (int i = 0; i <= PER; i++) begin
      @(negedge clk);
      chk("tab_an", bus.an, an_tab[i % PER]);
      chk("tab_nib", bus.nib, nib_tab[i % PER]);
      chk("tab_frame", bus.frame, (i % PER) == 0);
    end

    // d0 changed on the 2nd cycle of SHOW0 stays invisible until next SHOW0.
    @(negedge clk);
    bus.d0 = 4'h7;
    for (int k = 2; k < PER; k++) begin
      @(negedge clk);
      if (k < DW) chk("d0_hold_nib", bus.nib, 4'h3);
    end
    @(negedge clk);
    chk("d0_new_frame", bus.frame, 1);
    chk("d0_new_nib", bus.nib, 4'h7);

    // en dropped during SHOW1, then re-raised with a new d0.
    repeat (S1 + 1) @(negedge clk);
    chk("in_show1_an", bus.an, 2'b01);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en_drop_an", bus.an, 2'b11);
    chk("en_drop_nib", bus.nib, 0);
    chk("en_drop_frame", bus.frame, 0);
    bus.d0 = 4'h5;
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_restart_an", bus.an, 2'b10);
    chk("en_restart_frame", bus.frame, 1);
    chk("en_restart_nib", bus.nib, 4'h5);

    // Reset asserted in the slot after SHOW0 (GAP0 when gaps are built in).
    repeat (DW) @(negedge clk);
    chk("pre_reset_an", bus.an, GAPS ? 2'b11 : 2'b01);
    chk("pre_reset_nib", bus.nib, GAPS ? 4'h5 : 4'hA);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_an", bus.an, 2'b11);
    chk("reset_mid_nib", bus.nib, 0);
    chk("reset_mid_frame", bus.frame, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_after_release2_an", bus.an, 2'b11);
    @(negedge clk);
    chk("restart2_an", bus.an, 2'b10);
    chk("restart2_frame", bus.frame, 1);
    chk("restart2_nib", bus.nib, 4'h5);

    // Free run with a new d1; the model covers these cycles.
    bus.d1 = 4'hC;
    repeat (2 * PER) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_mux.md
# seg_mux

Time-multiplexing driver for a dual-digit common-anode seven-segment display. It alternates two 4-bit hex digits onto a single nibble bus feeding the hex-to-segment decoder directly downstream. It generates the matching active-low anode enables. Optional blanking gaps between digits suppress ghosting from PNP transistor turn-off lag.

## Interface
Parameters:
- DWELL, 24000: cycles each digit is lit (2 kHz slot at 48 MHz); must be ≥2.
- BLANK, 512: cycles of dark gap after each digit; must be ≥1; ignored when gaps are compiled out.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  display enable; low forces display dark.
- d0  in  4  digit 0 value (right digit).
- d1  in  4  digit 1 value (left digit).
- nib  out  4  nibble to downstream segment decoder.
- an  out  2  anode enables, active-low; an[0]=digit 0, an[1]=digit 1.
- frame  out  1  one-cycle pulse at the start of each refresh frame.

## Operation
- States: IDLE, SHOW0, GAP0, SHOW1, GAP1.
- Registers: state, slot counter cnt, latched digits d0q and d1q.
- Reset: state=IDLE, cnt=0, d0q=d1q=0.
- IDLE -> SHOW0 when en=1; d0q<=d0, cnt<=0.
- SHOW0 at cnt==DWELL-1 -> GAP0 (cnt<=0).
- GAP0 at cnt==BLANK-1 -> SHOW1; d1q<=d1, cnt<=0.
- SHOW1 at cnt==DWELL-1 -> GAP1 (cnt<=0).
- GAP1 at cnt==BLANK-1 -> SHOW0; d0q<=d0, cnt<=0.
- Otherwise cnt increments each cycle.
- en=0 in any state -> IDLE next cycle, cnt<=0. en has lower priority than reset.
- Digit inputs are sampled only on slot entry. Changes on d0/d1 mid-slot are invisible until that digit's next slot.
- Output decode:
  - an=2'b10 in SHOW0; an=2'b01 in SHOW1; an=2'b11 in IDLE and both GAP states.
  - nib=d0q in SHOW0/GAP0; nib=d1q in SHOW1/GAP1; nib=4'h0 in IDLE.
- frame=1 iff state==SHOW0 and cnt==0.
- cnt width: $clog2(max(DWELL,BLANK)). Counter compares on terminal count and never wraps past it.
- Reset values of outputs: an=2'b11, nib=4'h0, frame=0.

## Timing
- All outputs are decoded from registers only. There is no combinational path from en, d0 or d1 to any output.
- Start latency: en sampled high in IDLE at edge t gives an=2'b10 and frame=1 in cycle t+1, showing the d0 value sampled at t.
- With gaps: each SHOW lasts exactly DWELL cycles and each GAP exactly BLANK cycles. Frame period is 2·(DWELL+BLANK).
- No cycle ever has both anodes low.
- Reset or en deassertion mid-slot blanks on the very next cycle. The next start always begins at SHOW0 with frame.

## Configuration
- SEG_MUX_BLANK_EN defined: GAP0/GAP1 present as described; BLANK is honoured.
- SEG_MUX_BLANK_EN undefined:
  - GAP states are removed.
  - SHOW0 terminal count -> SHOW1 (latch d1). SHOW1 terminal count -> SHOW0 (latch d0, frame).
  - Frame period is 2·DWELL.
  - an switches directly between 2'b10 and 2'b01.

## Structure
- Package seg_mux_pkg contains:
  - the state enum typedef (IDLE, SHOW0, GAP0, SHOW1, GAP1);
  - default constants DWELL_DEF=24000 and BLANK_DEF=512;
  - anode encoding constants AN_OFF=2'b11, AN_D0=2'b10, AN_D1=2'b01.
- One sub-module, slot_counter:
  - parameterised-width counter with sync clear and terminal-count compare input;
  - outputs cnt and tc;
  - instantiated once and shared by all states.
- The downstream segment decoder is instantiated at top level, not inside seg_mux.

## Test plan
Bench uses DWELL=4, BLANK=2, d0=4'h3, d1=4'hA unless noted.
- Reset held 3 cycles with en=1 -> an=2'b11, nib=0, frame=0 during reset. Cycle after release still IDLE. Then an=2'b10, nib=3, frame=1 for one cycle.
- Macro on, free run -> an sequence 10×4, 11×2, 01×4 (nib=A), 11×2. frame pulses every 12 cycles; never an=2'b00.
- Macro off, free run -> an alternates 10×4 (nib=3), 01×4 (nib=A). frame every 8 cycles; an=2'b11 never seen after start.
- d0 changed 3->7 on 2nd cycle of SHOW0 -> nib stays 3 for rest of slot. nib=7 first appears at the next SHOW0 entry.
- en dropped during SHOW1 -> next cycle an=2'b11, nib=0. en re-raised -> one cycle later SHOW0 with frame=1 and nib=current d0.
- reset asserted during GAP0 -> next cycle an=2'b11, nib=0, frame=0. Restart after release matches scenario 1.
